alu_muldiv: RTL and testbench

// Multi-cycle RV32M-style multiply/divide unit sitting beside the single-cycle ALU in EXU.

---
 rtl/alu_muldiv_if.sv | 25 ++
 rtl/alu_muldiv.sv | 206 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between EXU and the multiply/divide unit.
interface alu_muldiv_if #(
  parameter int unsigned BW   = 32,
  parameter int unsigned OP_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [BW-1:0]   d1;
  logic [BW-1:0]   d2;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   res;
  logic            div_zero;

  modport master (
    output in_valid, op, d1, d2, out_ready,
    input  in_ready, out_valid, res, div_zero
  );

  modport slave (
    input  in_valid, op, d1, d2, out_ready,
    output in_ready, out_valid, res, div_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M-style multiply/divide: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
module alu_muldiv #(
  parameter int unsigned BW   = 32,
  parameter int unsigned OP_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  alu_muldiv_if.slave bus
);
  localparam int unsigned PW    = 2 * BW;
  localparam int unsigned CNT_W = $clog2(BW) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BW - 1);
  localparam logic [BW-1:0]    MIN_V = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0]    ONES  = '1;

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(7);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [BW-1:0]    opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [BW:0]      acc_hi_q, acc_hi_d;  // product high / partial remainder
  logic [BW-1:0]    acc_lo_q, acc_lo_d;  // multiplier bits / quotient bits
  logic             neg_q, neg_d;        // product or quotient sign
  logic             rneg_q, rneg_d;      // remainder sign
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [BW-1:0]    res_q, res_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             in_div, in_rem, s1, s2, d1_neg, d2_neg, zero_in, ovf_in;
  logic [BW-1:0]    m1, m2;
  logic             is_div_q;
  logic [BW:0]      mul_sum;
  logic [PW:0]      mul_sh;
  logic [BW:0]      div_sh;
  logic [BW+1:0]    div_trial;
  logic [BW:0]      step_hi;
  logic [BW-1:0]    step_lo;
  logic [PW-1:0]    prod, prod_s;
  logic [BW-1:0]    quo, rem, fin_res;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.div_zero  = dz_q;

  assign accept = bus.in_valid & in_ready_q & ~flush;

  // Request decode: signedness, operand magnitudes, special divide cases
  always_comb begin
    in_div  = (bus.op == OP_DIV) | (bus.op == OP_DIVU) | (bus.op == OP_REM) | (bus.op == OP_REMU);
    in_rem  = (bus.op == OP_REM) | (bus.op == OP_REMU);
    s1      = (bus.op == OP_MULH) | (bus.op == OP_MULHSU) | (bus.op == OP_DIV) | (bus.op == OP_REM);
    s2      = (bus.op == OP_MULH) | (bus.op == OP_DIV) | (bus.op == OP_REM);
    d1_neg  = s1 & bus.d1[BW-1];
    d2_neg  = s2 & bus.d2[BW-1];
    m1      = d1_neg ? -bus.d1 : bus.d1;
    m2      = d2_neg ? -bus.d2 : bus.d2;
    zero_in = in_div & (bus.d2 == '0);
    ovf_in  = ((bus.op == OP_DIV) | (bus.op == OP_REM)) & (bus.d1 == MIN_V) & (bus.d2 == ONES);
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    is_div_q  = (op_q == OP_DIV) | (op_q == OP_DIVU) | (op_q == OP_REM) | (op_q == OP_REMU);
    mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_sh    = {mul_sum, acc_lo_q} >> 1;
    div_sh    = {acc_hi_q[BW-1:0], acc_lo_q[BW-1]};
    div_trial = {1'b0, div_sh} - {2'b00, opnd_q};
    step_hi   = mul_sh[PW:BW];
    step_lo   = mul_sh[BW-1:0];
    if (is_div_q) begin
      if (!div_trial[BW+1]) begin
        step_hi = div_trial[BW:0];
        step_lo = {acc_lo_q[BW-2:0], 1'b1};
      end else begin
        step_hi = div_sh;
        step_lo = {acc_lo_q[BW-2:0], 1'b0};
      end
    end
    prod   = {step_hi[BW-1:0], step_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -step_lo : step_lo;
    rem    = rneg_q ? -step_hi[BW-1:0] : step_hi[BW-1:0];
    case (op_q)
      OP_MUL:                       fin_res = prod_s[BW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[PW-1:BW];
      OP_DIV, OP_DIVU:              fin_res = quo;
      default:                      fin_res = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (zero_in | ovf_in) ? DONE : BUSY;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output/datapath next values
  always_comb begin
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    dz_d        = dz_q;
    in_ready_d  = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = bus.op;
          opnd_d   = in_div ? m2 : m1;
          acc_lo_d = in_div ? m1 : m2;
          acc_hi_d = '0;
          neg_d    = d1_neg ^ d2_neg;
          rneg_d   = d1_neg;
          cnt_d    = '0;
          if (zero_in) begin
            out_valid_d = 1'b1;
            dz_d        = 1'b1;
            res_d       = in_rem ? bus.d1 : ONES;
          end else if (ovf_in) begin
            out_valid_d = 1'b1;
            dz_d        = 1'b0;
            res_d       = in_rem ? '0 : MIN_V;
          end
        end
      end
      BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          dz_d        = 1'b0;
          res_d       = fin_res;
        end
      end
      DONE:    if (bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      opnd_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      dz_q        <= 1'b0;
    end else begin
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      dz_q        <= dz_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases, handshake,
// flush/reset behaviour and randomized ops against an arithmetic model.
module tb_alu_muldiv;
  localparam int unsigned BW   = 32;
  localparam int unsigned OP_W = 3;
  localparam int          NRAND = 1500;
  localparam logic [BW-1:0] MIN_V = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0] ONES  = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_muldiv_if #(.BW(BW), .OP_W(OP_W)) bus ();

  alu_muldiv #(.BW(BW), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] r;
    logic          z;
    int            lat;
  } vec_t;

  // Arithmetic reference: {div_zero, res} from plain wide signed math
  function automatic logic [BW:0] ref_model(input logic [2:0] op, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    logic signed [2*BW-1:0] x, y, p;
    logic signed [BW:0]     n, d, q, r;
    logic [BW-1:0]          res;
    logic                   dz;
    dz = 1'b0;
    if (op < 3'd4) begin
      x = (op == 3'd1 || op == 3'd2) ? {{BW{a[BW-1]}}, a} : {{BW{1'b0}}, a};
      y = (op == 3'd1) ? {{BW{b[BW-1]}}, b} : {{BW{1'b0}}, b};
      p = x * y;
      res = (op == 3'd0) ? p[BW-1:0] : p[2*BW-1:BW];
    end else if (b == '0) begin
      dz  = 1'b1;
      res = (op == 3'd4 || op == 3'd5) ? ONES : a;
    end else begin
      n = (op == 3'd4 || op == 3'd6) ? {a[BW-1], a} : {1'b0, a};
      d = (op == 3'd4 || op == 3'd6) ? {b[BW-1], b} : {1'b0, b};
      q = n / d;
      r = n % d;
      res = (op == 3'd4 || op == 3'd5) ? q[BW-1:0] : r[BW-1:0];
    end
    return {dz, res};
  endfunction

  function automatic logic [BW-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MIN_V;
      2:       return ONES;
      3:       return BW'(1);
      default: return BW'($urandom);
    endcase
  endfunction

  // Drive one request, wait (bounded) for the result, then retire it
  task automatic run_op(input logic [2:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        output logic [BW-1:0] r, output logic z, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    bus.op = OP_W'(op); bus.d1 = a; bus.d2 = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = bus.res;
    z = bus.div_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.res !== '0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b vld=%b res=%h dz=%b required 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.res, bus.div_zero);
    end
    checks++;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
  endtask

  task automatic test_directed();
    vec_t v[12];
    logic [BW-1:0] r;
    logic z;
    int lat;
    v[0]  = '{3'd0, BW'(7),   BW'(-3), BW'(-21), 1'b0, BW+1};
    v[1]  = '{3'd1, BW'(7),   BW'(-3), ONES,     1'b0, BW+1};
    v[2]  = '{3'd3, ONES,     ONES,    BW'(-2),  1'b0, BW+1};
    v[3]  = '{3'd2, ONES,     ONES,    ONES,     1'b0, BW+1};
    v[4]  = '{3'd4, BW'(-7),  BW'(2),  BW'(-3),  1'b0, BW+1};
    v[5]  = '{3'd6, BW'(-7),  BW'(2),  BW'(-1),  1'b0, BW+1};
    v[6]  = '{3'd5, BW'(100), BW'(7),  BW'(14),  1'b0, BW+1};
    v[7]  = '{3'd7, BW'(100), BW'(7),  BW'(2),   1'b0, BW+1};
    v[8]  = '{3'd4, BW'(5),   '0,      ONES,     1'b1, 1};
    v[9]  = '{3'd7, BW'(9),   '0,      BW'(9),   1'b1, 1};
    v[10] = '{3'd4, MIN_V,    ONES,    MIN_V,    1'b0, 1};
    v[11] = '{3'd6, MIN_V,    ONES,    '0,       1'b0, 1};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
      if (r !== v[i].r || z !== v[i].z || lat != v[i].lat) begin
        errors++;
        $display("FAIL directed[%0d] op=%0d: res=%h dz=%b lat=%0d required res=%h dz=%b lat=%0d",
                 i, v[i].op, r, z, lat, v[i].r, v[i].z, v[i].lat);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int lat;
    bus.op = OP_W'(0); bus.d1 = BW'(7); bus.d2 = BW'(-3); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.op = OP_W'(5); bus.d1 = BW'(100); bus.d2 = BW'(7);
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res !== BW'(-21)) begin
        errors++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b res=%h required 1 0 %h",
                 c, bus.out_valid, bus.in_ready, bus.res, BW'(-21));
      end
      checks++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire_no_accept: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_next: rdy=%b required 0", bus.in_ready);
    end
    checks++;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.res !== BW'(14) || lat != BW + 1) begin
      errors++;
      $display("FAIL second_op: res=%h lat=%0d required %h %0d", bus.res, lat, BW'(14), BW + 1);
    end
    checks++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    bus.op = OP_W'(5); bus.d1 = BW'(100); bus.d2 = BW'(7); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    repeat (BW + 8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid rose=%b required 0", seen);
    end
    checks++;
    bus.op = OP_W'(4); bus.d1 = BW'(5); bus.d2 = '0; bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_reject: rdy=%b vld=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
  endtask

  task automatic test_rst_mid();
    logic seen = 1'b0;
    bus.op = OP_W'(0); bus.d1 = BW'(123); bus.d2 = BW'(45); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.res !== '0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: rdy=%b vld=%b res=%h dz=%b required 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.res, bus.div_zero);
    end
    checks++;
    @(posedge clk); #1; rst = 1'b0;
    repeat (BW + 8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    if (seen !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_after: vld_seen=%b rdy=%b required 0 1", seen, bus.in_ready);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [2:0]    op;
    logic [BW-1:0] a, b, r;
    logic [BW:0]   exp;
    logic          z, special;
    int            lat;
    for (int i = 0; i < NRAND; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      exp = ref_model(op, a, b);
      special = (op >= 3'd4 && b == '0) ||
                ((op == 3'd4 || op == 3'd6) && a == MIN_V && b == ONES);
      run_op(op, a, b, r, z, lat);
      if (r !== exp[BW-1:0] || z !== exp[BW] || lat != (special ? 1 : BW + 1)) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: res=%h dz=%b lat=%0d required res=%h dz=%b lat=%0d",
                 i, op, a, b, r, z, lat, exp[BW-1:0], exp[BW], special ? 1 : BW + 1);
      end
      checks++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.d1 = '0;
    bus.d2 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
